counter_sweep_ctrl: RTL

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

---
 rtl/counter_sweep_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - bounded up/down counter sweep controller with pass count, hold and abort
module counter_sweep_ctrl #(
    parameter int WIDTH  = 10,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    input  logic              hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  cnt,
    output logic              mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] pass_left
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    // Bounds are compared before stepping, so cnt turns around at lo/hi and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pass_left <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ((lo < hi) && (passes != '0)) begin
                            state     <= UP;
                            cnt       <= lo;
                            mode      <= 1'b1;
                            busy      <= 1'b1;
                            pass_left <= passes;
                            lo_q      <= lo;
                            hi_q      <= hi;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!hold) begin
                        if (cnt == hi_q) begin
                            state <= DOWN;
                            mode  <= 1'b0;
                            cnt   <= cnt - WIDTH'(1);
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!hold) begin
                        if (cnt != lo_q) begin
                            cnt <= cnt - WIDTH'(1);
                        end else if (pass_left > PASS_W'(1)) begin
                            state     <= UP;
                            mode      <= 1'b1;
                            cnt       <= cnt + WIDTH'(1);
                            pass_left <= pass_left - PASS_W'(1);
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            pass_left <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
